// File: rtl/relu_stream_pkg.sv
// Shared types for the streaming activation layer: activation modes and
// the two-state beat sequencer encoding.
package relu_stream_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    BYPASS = 2'd0,
    RELU   = 2'd1,
    LEAKY  = 2'd2,
    CLIP   = 2'd3
  } act_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/relu_lane_act.sv
// Single-element activation (bypass / relu / leaky relu / clipped relu).
// Purely combinational; results always fit WIDTH so no saturation is needed.
module relu_lane_act
  import relu_stream_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int LEAK_SHIFT = 3
) (
  input  act_mode_t               mode,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] clip_val,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] ceil_s;

  // Select the activation; a negative ceiling collapses clipped mode to zero.
  always_comb begin
    ceil_s = clip_val[WIDTH-1] ? '0 : clip_val;
    y      = x;
    case (mode)
      BYPASS: y = x;
      RELU: begin
        if (x[WIDTH-1]) y = '0;
        else            y = x;
      end
      LEAKY: begin
        if (x[WIDTH-1]) y = x >>> LEAK_SHIFT;
        else            y = x;
      end
      CLIP: begin
        if (x[WIDTH-1])      y = '0;
        else if (x > ceil_s) y = ceil_s;
        else                 y = x;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/relu_stream_layer.sv
// Streaming activation layer: accepts a SIZE-element vector, emits SIZE/LANES
// activated beats. Optional negative-element counter under RELU_STATS_EN.
module relu_stream_layer
  import relu_stream_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int NFRAC      = 5,
  parameter int SIZE       = 32,
  parameter int LANES      = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MODE_W-1:0]        mode,
  input  logic [WIDTH-1:0]         clip_val,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*SIZE-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*LANES-1:0]   out_data,
  output logic                     out_last
`ifdef RELU_STATS_EN
  ,
  output logic [$clog2(SIZE+1)-1:0] neg_count
`endif
);

  localparam int NBEATS = SIZE / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);
  localparam logic SINGLE_BEAT = (NBEATS == 1);

  if ((SIZE % LANES) != 0 || NFRAC >= WIDTH) begin : g_cfg_check
    $error("relu_stream_layer: SIZE must be a multiple of LANES and NFRAC < WIDTH");
  end

  state_t                   state_q, state_d;
  logic [WIDTH*SIZE-1:0]    vec_q, vec_d;
  act_mode_t                mode_q, mode_d;
  logic [WIDTH-1:0]         clip_q, clip_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [WIDTH*LANES-1:0]   out_data_q, out_data_d;

  logic                     accept_s, advance_s, finish_s;
  logic [WIDTH*SIZE-1:0]    src_vec_s;
  act_mode_t                src_mode_s;
  logic [WIDTH-1:0]         src_clip_s;
  logic [CNT_W-1:0]         sel_s;
  logic [WIDTH*LANES-1:0]   beat_s [NBEATS];
  logic [WIDTH*LANES-1:0]   cur_beat_s;
  logic [WIDTH*LANES-1:0]   act_beat_s;

  assign in_ready  = (state_q == IDLE) || (out_valid_q && out_ready && out_last_q);
  assign accept_s  = in_valid && in_ready;
  assign advance_s = out_valid_q && out_ready && !out_last_q;
  assign finish_s  = out_valid_q && out_ready && out_last_q;

  // Beat 0 is activated straight from the incoming vector on the accept edge.
  always_comb begin
    if (accept_s) begin
      src_vec_s  = in_data;
      src_mode_s = act_mode_t'(mode);
      src_clip_s = clip_val;
      sel_s      = '0;
    end else begin
      src_vec_s  = vec_q;
      src_mode_s = mode_q;
      src_clip_s = clip_q;
      sel_s      = cnt_q + CNT_W'(1);
    end
  end

  for (genvar b = 0; b < NBEATS; b++) begin : g_beat
    assign beat_s[b] = src_vec_s[b*LANES*WIDTH +: LANES*WIDTH];
  end

  assign cur_beat_s = beat_s[sel_s];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    relu_lane_act #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_act (
      .mode     (src_mode_s),
      .x        (cur_beat_s[l*WIDTH +: WIDTH]),
      .clip_val (src_clip_s),
      .y        (act_beat_s[l*WIDTH +: WIDTH])
    );
  end

  // Sequencer next state: a same-edge accept wins over end-of-vector.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    mode_d      = mode_q;
    clip_d      = clip_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (accept_s) begin
      state_d     = BUSY;
      vec_d       = in_data;
      mode_d      = act_mode_t'(mode);
      clip_d      = clip_val;
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_last_d  = SINGLE_BEAT;
      out_data_d  = act_beat_s;
    end else if (advance_s) begin
      cnt_d       = cnt_q + CNT_W'(1);
      out_last_d  = ((cnt_q + CNT_W'(1)) == LAST_CNT);
      out_data_d  = act_beat_s;
    end else if (finish_s) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      state_d     = state_q;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      mode_q      <= BYPASS;
      clip_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      mode_q      <= mode_d;
      clip_q      <= clip_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

`ifdef RELU_STATS_EN
  localparam int NEG_W = $clog2(SIZE + 1);

  logic [NEG_W-1:0] neg_q, neg_d, neg_pop_s;

  // Count sign bits of the incoming vector; latched only on accept.
  always_comb begin
    neg_pop_s = '0;
    for (int i = 0; i < SIZE; i++) begin
      neg_pop_s = neg_pop_s + NEG_W'(in_data[i*WIDTH + WIDTH - 1]);
    end
    if (accept_s) neg_d = neg_pop_s;
    else          neg_d = neg_q;
  end

  // Negative-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= '0;
    else        neg_q <= neg_d;
  end

  assign neg_count = neg_q;
`endif

endmodule

// File: tb/tb_relu_stream_layer.sv
// Self-checking bench for relu_stream_layer: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_relu_stream_layer;

  localparam int WIDTH      = 10;
  localparam int SIZE       = 32;
  localparam int LANES      = 8;
  localparam int LEAK_SHIFT = 3;
  localparam int NBEATS     = SIZE / LANES;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       clip_val;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH*SIZE-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH*LANES-1:0] out_data;
  logic                   out_last;
`ifdef RELU_STATS_EN
  logic [$clog2(SIZE+1)-1:0] neg_count;
`endif

  always #5 clk = ~clk;

  relu_stream_layer #(
    .WIDTH(WIDTH), .NFRAC(5), .SIZE(SIZE), .LANES(LANES), .LEAK_SHIFT(LEAK_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clip_val(clip_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
`ifdef RELU_STATS_EN
    , .neg_count(neg_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [31:0] out_el(input int i);
    logic signed [WIDTH-1:0] e;
    e = out_data[i*WIDTH +: WIDTH];
    return {{(32-WIDTH){e[WIDTH-1]}}, e};
  endfunction

  function automatic int in_el(input int i);
    logic signed [WIDTH-1:0] e;
    e = in_data[i*WIDTH +: WIDTH];
    return int'(e);
  endfunction

  // Reference activation in plain integer arithmetic (leaky uses floor division).
  function automatic int ref_act(input int x, input int m, input int c);
    int cc, d;
    cc = (c < 0) ? 0 : c;
    d  = 1 << LEAK_SHIFT;
    case (m)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: return (x < 0) ? -((-x + d - 1) / d) : x;
      default: return (x < 0) ? 0 : ((x > cc) ? cc : x);
    endcase
  endfunction

  // Scoreboard: expected lane values and last flags, in beat order.
  logic signed [31:0] exp_el_q[$];
  bit                 exp_last_q[$];
  bit                 neg_pend = 1'b0;
  int                 neg_exp  = 0;

  always @(negedge clk) begin : mon
    int m, c, nneg;
    if (rst_n) begin
`ifdef RELU_STATS_EN
      if (neg_pend) begin
        chk("neg_count", 32'(neg_count), neg_exp);
        neg_pend = 1'b0;
      end
`endif
      if (out_valid && out_ready) begin
        if (exp_last_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got a beat, expected none (t=%0t)", $time);
        end else begin
          for (int i = 0; i < LANES; i++) chk($sformatf("beat_lane%0d", i), out_el(i), exp_el_q.pop_front());
          chk("out_last", 32'(out_last), 32'(exp_last_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        m    = int'(mode);
        c    = int'($signed(clip_val));
        nneg = 0;
        for (int b = 0; b < NBEATS; b++) begin
          for (int i = 0; i < LANES; i++) exp_el_q.push_back(ref_act(in_el(b*LANES + i), m, c));
          exp_last_q.push_back(b == NBEATS - 1);
        end
        for (int i = 0; i < SIZE; i++) if (in_el(i) < 0) nneg++;
        neg_exp  = nneg;
        neg_pend = 1'b1;
      end
    end
  end

  task automatic rand_vec();
    for (int i = 0; i < SIZE; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic send_vec(input int m, input int c);
    bit done;
    done     = 1'b0;
    mode     = m[1:0];
    clip_val = c[WIDTH-1:0];
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (exp_last_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    chk("drain", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int mode;
    int clip;
    int x[4];
    int y[4];
  } tv_t;

  tv_t tv[6];
  logic [WIDTH*LANES-1:0] saved_data;
  logic                   saved_last;

  initial begin
    tv[0] = '{1, 0,   '{-32, 0, 31, 511},  '{0, 0, 31, 511}};
    tv[1] = '{2, 0,   '{-32, -1, -512, 40}, '{-4, -1, -64, 40}};
    tv[2] = '{3, 192, '{200, 192, -5, 100}, '{192, 192, 0, 100}};
    tv[3] = '{3, -10, '{200, 5, -5, 0},     '{0, 0, 0, 0}};
    tv[4] = '{0, 0,   '{-512, 511, -1, 7},  '{-512, 511, -1, 7}};
    tv[5] = '{2, 0,   '{-9, -8, -7, 0},     '{-2, -1, -1, 0}};

    // Reset with in_valid high.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    mode      = 2'd1;
    clip_val  = '0;
    rand_vec();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data_zero", 32'(out_data == '0), 32'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      rand_vec();
      for (int i = 0; i < 4; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(tv[t].x[i]);
      send_vec(tv[t].mode, tv[t].clip);
      @(negedge clk);
      chk($sformatf("tv%0d_valid", t), 32'(out_valid), 32'd1);
      for (int i = 0; i < 4; i++) chk($sformatf("tv%0d_lane%0d", t, i), out_el(i), tv[t].y[i]);
      drain();
    end

    // Backpressure mid-vector with a mode change that must not take effect.
    rand_vec();
    send_vec(2, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    mode      = 2'd0;
    clip_val  = WIDTH'($urandom);
    rand_vec();
    @(negedge clk);
    saved_data = out_data;
    saved_last = out_last;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_data_stable", 32'(out_data == saved_data), 32'd1);
      chk("bp_last_stable", 32'(out_last), 32'(saved_last));
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Back-to-back vectors: 13 negatives, then none.
    for (int i = 0; i < SIZE; i++)
      in_data[i*WIDTH +: WIDTH] = (i < 13) ? WIDTH'(-int'($urandom_range(1, 512))) : WIDTH'($urandom_range(0, 511));
    mode     = 2'd1;
    in_valid = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
        @(posedge clk);
        #1;
      end
      chk("b2b_first_accept", 32'(got), 32'd1);
    end
    for (int i = 0; i < SIZE; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 511));
    for (int k = 0; k < 2 * NBEATS; k++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      if (k == NBEATS - 1) chk("b2b_in_ready_last", 32'(in_ready), 32'd1);
`ifdef RELU_STATS_EN
      if (k == 0)      chk("b2b_neg13", 32'(neg_count), 32'd13);
      if (k == NBEATS) chk("b2b_neg0", 32'(neg_count), 32'd0);
`endif
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Randomized traffic.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom);
      clip_val  = WIDTH'($urandom_range(0, 1) != 0 ? $urandom_range(0, 300) : $urandom);
      rand_vec();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while a vector is buffered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_vec();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_el_q.delete();
    exp_last_q.delete();
    neg_pend = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_beats", 32'(out_valid), 32'd0);
    end
    chk("sb_empty", 32'(exp_last_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
